// File: rtl/v_mul_pipe.sv
// v_mul_pipe: pipelined lane-wise vector multiplier (8/16/32-bit elements), high-half ops enabled by V_MUL_HIGH_EN
module v_mul_pipe #(
   parameter int DATA_W = 32,
   parameter int STAGES = 3
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] op_A,
   input  logic [DATA_W-1:0] op_B,
   input  logic [2:0]        sew,
   input  logic [1:0]        op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic              err
);
   logic [2:0][DATA_W-1:0] w_lane;
   logic [DATA_W-1:0]      w_res;
   logic                   w_err;
   logic                   w_bad_op;
   logic                   w_adv;
   logic [STAGES-1:0]      r_v;
   logic [STAGES-1:0]      r_e;
   logic [DATA_W-1:0]      r_d [STAGES];
`ifdef V_MUL_HIGH_EN
   logic w_sa, w_sb, w_hi;
   assign w_sa     = op != 2'b10;
   assign w_sb     = !op[1];
   assign w_hi     = op != 2'b00;
   assign w_bad_op = 1'b0;
`else
   assign w_bad_op = op != 2'b00;
`endif
   for (genvar k = 0; k < 3; k++) begin : g_w
      localparam int SEW = 8 << k;
      for (genvar e = 0; e < DATA_W / SEW; e++) begin : g_e
         logic [SEW-1:0] w_a, w_b;
         assign w_a = op_A[e*SEW +: SEW];
         assign w_b = op_B[e*SEW +: SEW];
`ifdef V_MUL_HIGH_EN
         logic [2*SEW-1:0] w_p;
         assign w_p = {{SEW{w_sa & w_a[SEW-1]}}, w_a} * {{SEW{w_sb & w_b[SEW-1]}}, w_b};
         assign w_lane[k][e*SEW +: SEW] = w_hi ? w_p[2*SEW-1:SEW] : w_p[SEW-1:0];
`else
         logic [SEW-1:0] w_p;
         assign w_p = w_a * w_b;
         assign w_lane[k][e*SEW +: SEW] = w_p;
`endif
      end
   end
   assign w_err    = (sew > 3'd2) | w_bad_op;
   assign w_adv    = !out_valid || out_ready;
   assign in_ready = w_adv;
   // select the lane set for the element width; illegal words carry zero data
   always_comb begin
      w_res = w_err ? '0 : sew == 3'd0 ? w_lane[0] : sew == 3'd1 ? w_lane[1] : w_lane[2];
   end
   // shift the whole pipe together on advance, hold everything on stall
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_v <= '0;
         r_e <= '0;
         for (int s = 0; s < STAGES; s++) r_d[s] <= '0;
      end else if (w_adv) begin
         r_v[0] <= in_valid;
         r_e[0] <= w_err;
         r_d[0] <= w_res;
         for (int s = 1; s < STAGES; s++) begin
            r_v[s] <= r_v[s-1];
            r_e[s] <= r_e[s-1];
            r_d[s] <= r_d[s-1];
         end
      end
   end
   assign out_valid = r_v[STAGES-1];
   assign result    = out_valid ? r_d[STAGES-1] : '0;
   assign err       = out_valid & r_e[STAGES-1];
endmodule

// File: doc/v_mul_pipe.md
# v_mul_pipe

Parametrised, pipelined vector integer multiplier for the coprocessor's execute stage. Splits a DATA_W-bit operand word into SEW-sized elements (8/16/32 bits), multiplies them lane-wise, and returns either the low half (vmul) or the high half (vmulh/vmulhu/vmulhsu) of each 2·SEW product. Uses a valid/ready handshake with full backpressure. Sits between the vector register-file read stage and the writeback arbiter.

## Interface
- DATA_W, 32, operand/result width; multiple of 32.
- STAGES, 3, pipeline depth (issue-to-result latency in cycles); ≥1.
- clk  in  1  clock, rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand word valid.
- in_ready  out  1  block accepts an operand word this cycle.
- op_A  in  DATA_W  operand vector A.
- op_B  in  DATA_W  operand vector B.
- sew  in  3  element width: 000=8, 001=16, 010=32; others illegal.
- op  in  2  00=vmul (low), 01=vmulh (s×s high), 10=vmulhu (u×u high), 11=vmulhsu (A signed × B unsigned, high).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  DATA_W  packed element results, element 0 in LSBs.
- err  out  1  sideband with result: illegal sew or disabled op.

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv. On adv, every stage shifts (valid bit, data, sew, op, err) one place; when adv=0, all stages hold.
- Element count: DATA_W/SEW. Element i uses bits [i·SEW +: SEW] of both operands.
- Extension to 2·SEW: A signed for op 00/01/11, unsigned for 10; B signed for op 00/01, unsigned for 10/11. (Low half is identical for signed/unsigned.)
- Product p = extA × extB, 2·SEW bits. op 00 → p[SEW-1:0]; otherwise p[2·SEW-1:SEW].
- Illegal sew (011–111): result 0, err 1; word still traverses the pipe with normal latency.
- Bubbles (in_valid=0 on adv) propagate as invalid stages; results are strictly in issue order.
- Pipe holds at most STAGES words; no word is dropped or duplicated under any out_ready pattern.

## Timing
- Reset (nrst low, async): all stage valids 0, out_valid 0, result 0, err 0. in_ready is 1 during and after reset (out_valid=0).
- Latency: word accepted at edge t appears with out_valid=1 after edge t+STAGES-1 if adv stays high (i.e. STAGES cycles).
- Throughput: one word/cycle with out_ready held high.
- Stall: out_valid=1 && out_ready=0 → in_ready=0 same cycle (combinational from out_ready); result/err stable until taken.
- Simultaneous out-transfer and in-transfer in the same cycle permitted.
- Reset mid-operation: all in-flight words discarded; no out_valid after reset release until a new word completes STAGES cycles.
- result/err undefined-free: when out_valid=0, result and err read 0.

## Configuration
- V_MUL_HIGH_EN defined: all four ops supported as above.
- Not defined: only op 00 implemented (no high-half logic/extension muxing); op≠00 returns result 0, err 1, with normal latency and handshake.

## Test plan
- DATA_W=32, STAGES=3, sew=000, op=00, A=0x05FF807F, B=0x03020202 → result 0x0FFE00FE, err 0, out_valid exactly 3 cycles after accept.
- sew=001, op=01, A=0x80007FFF, B=0x80007FFF → result 0x40003FFF.
- sew=010: op=10, A=B=0xFFFFFFFF → 0xFFFFFFFE; op=11, A=0xFFFFFFFF, B=0x00000002 → 0xFFFFFFFF; op=01, same operands → 0xFFFFFFFF.
- Backpressure: 5 back-to-back words, out_ready=0 for 6 cycles then 1 → in_ready falls after 3 accepted, all 5 results emerge in order, none lost or duplicated.
- sew=011, any op → result 0, err 1; with V_MUL_HIGH_EN undefined, sew=000 op=01 → result 0, err 1.
- Assert nrst low with 3 words in flight → out_valid, result, err 0 immediately; after release, none of the old words appear.
